mem_mfc_ctrl: RTL

MEM_MFC_CTRL -- requirements
Module: mem_mfc_ctrl

---
 rtl/mem_mfc_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_mfc_ctrl.sv
// Byte-addressed big-endian memory behind a MOV/MFC request handshake,
// with programmable wait states and size/alignment fault detection.
module mem_mfc_ctrl #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        MAS,
  input  logic              SE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       DATA_IN,
  output logic [31:0]       DATA_OUT,
  output logic              MFC,
  output logic              BUSY,
  output logic              ERR
);

  localparam int         DEPTH   = 2 ** ADDR_W;
  localparam logic [3:0] WS      = 4'(WAIT_STATES);
  localparam logic [3:0] WS_LAST = WS - 4'd1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              rw_q;
  logic              se_q;
  logic [1:0]        mas_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [7:0]        mem_q [DEPTH];

  logic              accept;
  logic              commit;
  logic              op_rw;
  logic              op_se;
  logic              op_err;
  logic              fill;
  logic [1:0]        op_mas;
  logic [ADDR_W-1:0] a0;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] a3;
  logic [31:0]       op_data;
  logic [31:0]       rdata;

  assign accept = (state_q == IDLE) && MOV;
  assign commit = (accept && WS == 4'd0)
               || (state_q == WAIT && cnt_q == WS_LAST);

  // With no wait states the commit shares the acceptance edge, so the
  // operation comes from the pins while IDLE and from the latch after.
  always_comb begin
    if (state_q == IDLE) begin
      op_rw   = RW;
      op_se   = SE;
      op_mas  = MAS;
      a0      = ADDR;
      op_data = DATA_IN;
    end else begin
      op_rw   = rw_q;
      op_se   = se_q;
      op_mas  = mas_q;
      a0      = addr_q;
      op_data = data_q;
    end
  end

  assign a1 = a0 + ADDR_W'(1);
  assign a2 = a0 + ADDR_W'(2);
  assign a3 = a0 + ADDR_W'(3);

  always_comb begin
    unique case (op_mas)
      2'b00:   op_err = 1'b0;
      2'b01:   op_err = a0[0];
      2'b10:   op_err = |a0[1:0];
      default: op_err = 1'b1;
    endcase
  end

  always_comb begin
    fill  = 1'b0;
    rdata = '0;
    unique case (op_mas)
      2'b00: begin
        fill  = op_se & mem_q[a0][7];
        rdata = {{24{fill}}, mem_q[a0]};
      end
      2'b01: begin
        fill  = op_se & mem_q[a0][7];
        rdata = {{16{fill}}, mem_q[a0], mem_q[a1]};
      end
      default: begin
        rdata = {mem_q[a0], mem_q[a1],
                 mem_q[a2], mem_q[a3]};
      end
    endcase
  end

  // Storage is never cleared; CLR only blocks a commit.
  always_ff @(posedge CLK) begin
    if (CLR && commit && !op_rw && !op_err) begin
      unique case (op_mas)
        2'b00: begin
          mem_q[a0] <= op_data[7:0];
        end
        2'b01: begin
          mem_q[a0] <= op_data[15:8];
          mem_q[a1] <= op_data[7:0];
        end
        default: begin
          mem_q[a0] <= op_data[31:24];
          mem_q[a1] <= op_data[23:16];
          mem_q[a2] <= op_data[15:8];
          mem_q[a3] <= op_data[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rw_q     <= 1'b0;
      se_q     <= 1'b0;
      mas_q    <= 2'b00;
      addr_q   <= '0;
      data_q   <= 32'h0;
      MFC      <= 1'b0;
      BUSY     <= 1'b0;
      ERR      <= 1'b0;
      DATA_OUT <= 32'h0;
    end else begin
      MFC <= 1'b0;
      ERR <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (MOV) begin
            rw_q    <= RW;
            se_q    <= SE;
            mas_q   <= MAS;
            addr_q  <= ADDR;
            data_q  <= DATA_IN;
            cnt_q   <= 4'd0;
            BUSY    <= 1'b1;
            state_q <= (WS == 4'd0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == WS_LAST) begin
            cnt_q   <= 4'd0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          BUSY    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      if (commit) begin
        MFC <= 1'b1;
        ERR <= op_err;
        if (op_rw && !op_err) begin
          DATA_OUT <= rdata;
        end
      end
    end
  end

endmodule
